// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD
    } fetch_state_t;

    localparam int unsigned PC_STEP       = 4;
    localparam logic [31:0] PC_RESET_ADDR = 32'h0000_0000;

endpackage

// File: rtl/single_adder.sv
// Plain N-bit adder; the sum wraps modulo 2^N and no carry is produced.
module single_adder #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/pc_fetch_stage.sv
// PC register and single-outstanding-request fetch controller feeding decode.
// Optional macro FETCH_ALIGN_CHECK_EN: word-align branch targets and flag misaligned ones.
module pc_fetch_stage
    import fetch_pkg::*;
#(
    parameter int          N          = 32,
    parameter logic [N-1:0] RESET_ADDR = PC_RESET_ADDR,
    parameter int unsigned STEP       = PC_STEP
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         branch_taken,
    input  logic [N-1:0] branch_target,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic         imem_ack,
    input  logic [N-1:0] imem_rdata,
    output logic [N-1:0] instr,
    output logic [N-1:0] instr_pc,
    output logic         instr_valid,
    input  logic         instr_ready
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic         misalign_err
`endif
);

    localparam logic [N-1:0] STEP_VEC = N'(STEP);

    fetch_state_t state;
    logic [N-1:0] pc;
    logic [N-1:0] pc_next;
    logic [N-1:0] branch_pc;

    single_adder #(
        .N(N)
    ) u_pc_adder (
        .a  (pc),
        .b  (STEP_VEC),
        .sum(pc_next)
    );

`ifdef FETCH_ALIGN_CHECK_EN
    assign branch_pc = {branch_target[N-1:2], 2'b00};
`else
    assign branch_pc = branch_target;
`endif

    assign imem_addr = pc;

    // A branch overrides everything but reset: it flushes the held instruction
    // and drops any response arriving in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            pc          <= RESET_ADDR;
            imem_req    <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            misalign_err <= 1'b0;
`endif
        end else begin
`ifdef FETCH_ALIGN_CHECK_EN
            misalign_err <= branch_taken && (branch_target[1:0] != 2'b00);
`endif
            if (branch_taken) begin
                pc          <= branch_pc;
                instr_valid <= 1'b0;
                state       <= en ? S_REQ : S_IDLE;
                imem_req    <= en;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (en) begin
                            state    <= S_REQ;
                            imem_req <= 1'b1;
                        end
                    end
                    S_REQ: begin
                        if (imem_ack) begin
                            instr       <= imem_rdata;
                            instr_pc    <= pc;
                            instr_valid <= 1'b1;
                            pc          <= pc_next;
                            state       <= S_HOLD;
                            imem_req    <= 1'b0;
                        end
                    end
                    S_HOLD: begin
                        if (instr_ready) begin
                            instr_valid <= 1'b0;
                            state       <= en ? S_REQ : S_IDLE;
                            imem_req    <= en;
                        end
                    end
                    default: begin
                        state    <= S_IDLE;
                        imem_req <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
